// File: rtl/led_cube_pkg.sv
`timescale 1ns/1ps
// led_cube_pkg
// Shared frame geometry and scheduler state encoding for the LED cube frame
// scheduler and its double-buffered frame store.
package led_cube_pkg;

    localparam int FRAME_BYTES = 64;  // 8 layers x 8 latch bytes
    localparam int ADDR_W      = 6;   // {layer, latch}
    localparam int BYTE_W      = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2,
        DRAIN    = 2'd3
    } sched_state_t;

endpackage

// File: rtl/cube_frame_buffer.sv
`timescale 1ns/1ps
// cube_frame_buffer
// Double-buffered 64-byte frame store. The host fills the back bank through a
// byte stream; the driver reads the front bank combinationally. A completed
// back frame is held (pending) until the scheduler requests a swap.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears both banks)
//   wr_valid     host byte valid
//   wr_sof       restart the frame: this byte lands at index 0
//   wr_data      host byte
//   wr_ready     back bank writable (no pending frame)
//   swap         exchange front/back banks and clear pending
//   addr         driver read address
//   rd_data      front_bank[addr]
//   pending      a complete frame waits in the back bank
module cube_frame_buffer
    import led_cube_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic              wr_sof,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              swap,
    input  logic [ADDR_W-1:0] addr,
    output logic [BYTE_W-1:0] rd_data,
    output logic              pending
);

    logic [BYTE_W-1:0] bank0_q [FRAME_BYTES];
    logic [BYTE_W-1:0] bank0_d [FRAME_BYTES];
    logic [BYTE_W-1:0] bank1_q [FRAME_BYTES];
    logic [BYTE_W-1:0] bank1_d [FRAME_BYTES];
    logic              front_q, front_d;     // 0: bank0 is front
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              pending_q, pending_d;
    logic              wr_fire;
    logic [ADDR_W-1:0] wr_idx;

    always_comb begin
        bank0_d   = bank0_q;
        bank1_d   = bank1_q;
        front_d   = front_q;
        wr_ptr_d  = wr_ptr_q;
        pending_d = pending_q;
        wr_fire   = wr_valid && !pending_q;
        wr_idx    = wr_sof ? '0 : wr_ptr_q;

        if (wr_fire) begin
            if (front_q) begin
                bank0_d[wr_idx] = wr_data;
            end else begin
                bank1_d[wr_idx] = wr_data;
            end
            // Pointer wraps 63 -> 0 naturally with the 6-bit width.
            wr_ptr_d = wr_idx + ADDR_W'(1);
            if (wr_idx == ADDR_W'(FRAME_BYTES - 1)) begin
                pending_d = 1'b1;
            end
        end

        // A swap is only requested while pending, when no write can be
        // accepted, so write and swap never collide.
        if (swap) begin
            front_d   = !front_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FRAME_BYTES; i++) begin
                bank0_q[i] <= '0;
                bank1_q[i] <= '0;
            end
            front_q   <= 1'b0;
            wr_ptr_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            bank0_q   <= bank0_d;
            bank1_q   <= bank1_d;
            front_q   <= front_d;
            wr_ptr_q  <= wr_ptr_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rd_data  = front_q ? bank1_q[addr] : bank0_q[addr];
        wr_ready = !pending_q;
        pending  = pending_q;
    end

endmodule

// File: rtl/led_cube_frame_scheduler.sv
`timescale 1ns/1ps
// led_cube_frame_scheduler
// Sequences the single-frame cube driver across an animation: owns the
// double-buffered frame store, swaps banks at frame boundaries after a
// programmable hold count, and generates the driver start/stop handshake.
//
// Optional build macro LED_CUBE_SCHED_BLANK_EN: when the hold expires with no
// new frame pending, the cube goes dark (data_to_latch=0) until the next swap.
// Without it the last frame repeats indefinitely.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         run animation while high
//   frame_hold     passes per frame (0 treated as 1), sampled at each swap
//   wr_valid/wr_sof/wr_data/wr_ready   host byte stream into the back bank
//   addr           driver read address, data_to_latch = front_bank[addr]
//   frame_done     driver end-of-pass pulse
//   start          one-cycle driver start pulse
//   stop           driver stop level
//   swap_pulse     one cycle, the cycle after a bank swap
//   running        high in RUN
//   frames_shown   frame_done count while in RUN (wraps)
module led_cube_frame_scheduler
    import led_cube_pkg::*;
#(
    parameter int HOLD_W       = 8,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [HOLD_W-1:0] frame_hold,
    input  logic              wr_valid,
    input  logic              wr_sof,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic              frame_done,
    output logic [BYTE_W-1:0] data_to_latch,
    output logic              start,
    output logic              stop,
    output logic              swap_pulse,
    output logic              running,
    output logic [CNT_W-1:0]  frames_shown
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    sched_state_t       state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   frames_shown_q, frames_shown_d;
    logic               start_q, start_d;
    logic               swap_pulse_q, swap_pulse_d;
`ifdef LED_CUBE_SCHED_BLANK_EN
    logic               blank_q, blank_d;
`endif
    logic               swap;
    logic               pending;
    logic [BYTE_W-1:0]  rd_data;
    logic [HOLD_W-1:0]  hold_load;

    cube_frame_buffer u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_sof   (wr_sof),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .swap     (swap),
        .addr     (addr),
        .rd_data  (rd_data),
        .pending  (pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            hold_cnt_q     <= HOLD_W'(1);
            drain_cnt_q    <= '0;
            frames_shown_q <= '0;
            start_q        <= 1'b0;
            swap_pulse_q   <= 1'b0;
`ifdef LED_CUBE_SCHED_BLANK_EN
            blank_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            frames_shown_q <= frames_shown_d;
            start_q        <= start_d;
            swap_pulse_q   <= swap_pulse_d;
`ifdef LED_CUBE_SCHED_BLANK_EN
            blank_q        <= blank_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        frames_shown_d = frames_shown_q;
        start_d        = 1'b0;
        swap_pulse_d   = 1'b0;
        swap           = 1'b0;
`ifdef LED_CUBE_SCHED_BLANK_EN
        blank_d        = blank_q;
`endif
        hold_load      = (frame_hold == '0) ? HOLD_W'(1) : frame_hold;

        case (state_q)
            IDLE: begin
                if (enable && pending) begin
                    swap    = 1'b1;
                    start_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (frame_done) begin
                    frames_shown_d = frames_shown_q + CNT_W'(1);
                end
                if (!enable) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (frame_done) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else if (enable) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // Driver needs this long to finish its last layer and park.
                if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame boundary: the swap decision sees the registered pending flag,
        // so a frame completing in this same cycle waits for the next pass.
        if ((state_q == RUN || state_q == STOPPING) && frame_done) begin
            if (hold_cnt_q > HOLD_W'(1)) begin
                hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end else if (pending) begin
                swap = 1'b1;
            end
`ifdef LED_CUBE_SCHED_BLANK_EN
            else begin
                blank_d = 1'b1;
            end
`endif
        end

        if (swap) begin
            hold_cnt_d   = hold_load;
            swap_pulse_d = 1'b1;
`ifdef LED_CUBE_SCHED_BLANK_EN
            blank_d      = 1'b0;
`endif
        end
    end

    always_comb begin
        stop         = (state_q == IDLE) || (state_q == DRAIN);
        running      = (state_q == RUN);
        start        = start_q;
        swap_pulse   = swap_pulse_q;
        frames_shown = frames_shown_q;
`ifdef LED_CUBE_SCHED_BLANK_EN
        data_to_latch = blank_q ? '0 : rd_data;
`else
        data_to_latch = rd_data;
`endif
    end

endmodule
